// File: rtl/aud_player.sv
// aud_player: SRAM-to-DAC mono playback serializer on the codec bit clock.
// Left-justified, MSB first, with normal/fast/slow rates, pause and stop.
module aud_player #(
   parameter int ADDR_W = 20,
   parameter int DATA_W = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_daclrck,
   input  logic              i_start,
   input  logic              i_pause,
   input  logic              i_stop,
   input  logic [1:0]        i_mode,
   input  logic [2:0]        i_speed,
   input  logic [ADDR_W-1:0] i_end_addr,
   input  logic [DATA_W-1:0] i_sram_data,
   output logic [ADDR_W-1:0] o_address,
   output logic              o_dacdat,
   output logic [1:0]        o_state,
   output logic              o_done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PAUSE = 2'd1,
      S_SEND  = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   state_t            state;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] sample;
   logic [CNT_W-1:0]  bit_cnt;
   logic [2:0]        rpt_cnt;
   logic              lrc_p;
   logic              term;
   logic              slot_r;

   logic              left_edge;
   logic              right_edge;
   logic              hold;
   logic              over;
   logic [ADDR_W:0]   step;
   logic [ADDR_W:0]   next_addr;

   assign left_edge  = lrc_p & ~i_daclrck;
   assign right_edge = ~lrc_p & i_daclrck;

   assign o_dacdat = (state == S_SEND) & shreg[DATA_W-1];
   assign o_state  = state;

   // One extra address bit so a step past the top of memory
   // is seen as "beyond the end" instead of wrapping to zero.
   always_comb begin
      step = (ADDR_W+1)'(1);
      hold = 1'b0;
      case (i_mode)
         2'b01: step = (ADDR_W+1)'(i_speed) + (ADDR_W+1)'(1);
         2'b10: hold = (rpt_cnt < i_speed);
         default: step = (ADDR_W+1)'(1);
      endcase
      next_addr = {1'b0, o_address} + step;
      over      = ~hold & (next_addr > {1'b0, i_end_addr});
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= S_IDLE;
         o_address <= '0;
         o_done    <= 1'b0;
         shreg     <= '0;
         sample    <= '0;
         bit_cnt   <= '0;
         rpt_cnt   <= '0;
         lrc_p     <= 1'b0;
         term      <= 1'b0;
         slot_r    <= 1'b0;
      end else begin
         lrc_p  <= i_daclrck;
         o_done <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (!i_stop && i_start) begin
                  o_address <= '0;
                  rpt_cnt   <= '0;
                  term      <= 1'b0;
                  state     <= S_WAIT;
               end
            end
            S_PAUSE: begin
               if (i_stop)
                  state <= S_IDLE;
               else if (i_start)
                  state <= S_WAIT;
            end
            S_WAIT: begin
               if (i_stop) begin
                  state <= S_IDLE;
               end else if (i_pause) begin
                  state <= S_PAUSE;
               end else if (left_edge) begin
                  shreg   <= i_sram_data;
                  sample  <= i_sram_data;
                  bit_cnt <= '0;
                  slot_r  <= 1'b0;
                  state   <= S_SEND;
                  if (hold) begin
                     rpt_cnt <= rpt_cnt + 3'd1;
                  end else begin
                     rpt_cnt <= '0;
                     if (over)
                        term <= 1'b1;
                     else
                        o_address <= next_addr[ADDR_W-1:0];
                  end
               end else if (right_edge) begin
                  shreg   <= sample;
                  bit_cnt <= '0;
                  slot_r  <= 1'b1;
                  state   <= S_SEND;
               end
            end
            S_SEND: begin
               if (i_stop) begin
                  state <= S_IDLE;
               end else if (i_pause) begin
                  state <= S_PAUSE;
               end else if (bit_cnt == LAST_BIT) begin
                  // Data runs out only after the right slot of the last frame.
                  if (term && slot_r) begin
                     state  <= S_IDLE;
                     o_done <= 1'b1;
                     term   <= 1'b0;
                  end else begin
                     state <= S_WAIT;
                  end
               end else begin
                  shreg   <= {shreg[DATA_W-2:0], 1'b0};
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aud_player.sv
// tb_aud_player: directed + randomized playback runs for aud_player.
// Serial slots are reassembled and compared with a frame-level model.
module tb_aud_player;

   localparam int AW = 20;
   localparam int DW = 16;
   localparam int LIM = 20000;

   logic          clk = 1'b0;
   logic          rst;
   logic          lrck = 1'b0;
   logic          start, pause, stop;
   logic [1:0]    mode;
   logic [2:0]    speed;
   logic [AW-1:0] end_addr;
   logic [AW-1:0] addr;
   logic [DW-1:0] sdata;
   logic          dacdat;
   logic [1:0]    state;
   logic          done;

   logic [3:0]    addr_s;
   logic [DW-1:0] sdata_s;
   logic          dacdat_s;
   logic [1:0]    state_s;
   logic          done_s;

   logic [DW-1:0] mem [0:63];
   int            vectors = 0;
   int            errors = 0;
   int            cyc = 0;
   int            done_cnt = 0;
   int            done_cnt_s = 0;
   logic [DW-1:0] cap = '0;
   logic          cap_ok = 1'b0;
   logic [DW-1:0] capq [$];
   logic [DW-1:0] expq [$];
   int            exp_fa;

   assign sdata   = mem[addr[5:0]];
   assign sdata_s = mem[{2'b00, addr_s}];

   aud_player #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_daclrck   (lrck),
      .i_start     (start),
      .i_pause     (pause),
      .i_stop      (stop),
      .i_mode      (mode),
      .i_speed     (speed),
      .i_end_addr  (end_addr),
      .i_sram_data (sdata),
      .o_address   (addr),
      .o_dacdat    (dacdat),
      .o_state     (state),
      .o_done      (done)
   );

   // Narrow-address copy: exercises the end-of-memory overflow case.
   aud_player #(.ADDR_W(4), .DATA_W(DW)) dut_s (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_daclrck   (lrck),
      .i_start     (start),
      .i_pause     (pause),
      .i_stop      (stop),
      .i_mode      (mode),
      .i_speed     (speed),
      .i_end_addr  (4'hF),
      .i_sram_data (sdata_s),
      .o_address   (addr_s),
      .o_dacdat    (dacdat_s),
      .o_state     (state_s),
      .o_done      (done_s)
   );

   always #5 clk = ~clk;

   // LRCK generation and slot reassembly; a slot counts only if the
   // DUT stayed in SEND for all 16 bits.
   always @(negedge clk) begin
      cyc  <= cyc + 1;
      lrck <= ((cyc + 1) % 64) >= 32;
      if (done)
         done_cnt <= done_cnt + 1;
      if (done_s)
         done_cnt_s <= done_cnt_s + 1;
      if ((cyc % 32) < 16) begin
         cap <= {cap[DW-2:0], dacdat};
         if ((cyc % 32) == 0)
            cap_ok <= (state == 2'd2);
         else
            cap_ok <= cap_ok && (state == 2'd2);
         if ((cyc % 32) == 15 && cap_ok && state == 2'd2)
            capq.push_back({cap[DW-2:0], dacdat});
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_pos(input int p);
      do step(); while ((cyc % 64) != p);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (state != 2'd0 && n < LIM) begin
         step();
         n++;
      end
      chk($sformatf("%s_timeout", tag), 32'(n < LIM), 32'd1);
   endtask

   // Frame-level model: every played address gives one left and one
   // right word; the walk stops once the next address passes the end.
   task automatic model(input int st, input logic [1:0] md, input int n,
                        input int e);
      int a, r, nx, guard;
      a = st;
      r = 0;
      guard = 0;
      expq = {};
      while (guard < 1000) begin
         guard++;
         expq.push_back(mem[a % 64]);
         expq.push_back(mem[a % 64]);
         if (md == 2'b10 && r < n - 1) begin
            r++;
            nx = a;
         end else begin
            r = 0;
            nx = a + ((md == 2'b01) ? n : 1);
         end
         if (nx > e)
            break;
         a = nx;
      end
      exp_fa = a;
   endtask

   task automatic check_words(input string tag);
      chk($sformatf("%s_len", tag), 32'(capq.size()), 32'(expq.size()));
      for (int i = 0; i < expq.size() && i < capq.size(); i++)
         chk($sformatf("%s_w%0d", tag, i), 32'(capq[i]), 32'(expq[i]));
   endtask

   task automatic kick();
      wait_pos(40);
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic play_run(input string tag, input logic [1:0] md,
                           input logic [2:0] sp, input int e);
      int d0;
      mode = md;
      speed = sp;
      end_addr = AW'(e);
      model(0, md, int'(sp) + 1, e);
      d0 = done_cnt;
      wait_pos(30);
      capq = {};
      kick();
      wait_idle(tag);
      step();
      step();
      check_words(tag);
      chk($sformatf("%s_addr", tag), 32'(addr), 32'(exp_fa));
      chk($sformatf("%s_done", tag), 32'(done_cnt - d0), 32'd1);
      chk($sformatf("%s_dac", tag), 32'(dacdat), 32'd0);
   endtask

   initial begin
      int d0;
      int ds;
      logic [1:0] md;
      logic [2:0] sp;
      int e;

      rst = 1'b1;
      start = 1'b0;
      pause = 1'b0;
      stop = 1'b0;
      mode = 2'b00;
      speed = 3'd0;
      end_addr = '0;
      for (int i = 0; i < 64; i++)
         mem[i] = DW'($urandom);
      mem[0] = 16'hA5F0;
      mem[1] = 16'h8001;
      mem[2] = 16'h7FFE;

      step();
      step();
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_dac", 32'(dacdat), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rst = 1'b0;

      play_run("normal", 2'b00, 3'd0, 2);
      chk("normal_first", 32'(capq[0]), 32'h0000A5F0);
      chk("normal_last", 32'(capq[capq.size()-1]), 32'h00007FFE);

      play_run("fast", 2'b01, 3'd2, 10);
      play_run("slow", 2'b10, 3'd1, 1);
      play_run("one", 2'b00, 3'd5, 0);

      for (int k = 0; k < 6; k++) begin
         md = 2'($urandom_range(0, 3));
         sp = (md == 2'b10) ? 3'($urandom_range(0, 3))
                            : 3'($urandom_range(0, 7));
         e = $urandom_range(0, 8);
         play_run($sformatf("rnd%0d", k), md, sp, e);
      end

      // Pause on bit 7 of the second left slot, then resume.
      mode = 2'b00;
      speed = 3'd0;
      end_addr = AW'(5);
      d0 = done_cnt;
      wait_pos(30);
      capq = {};
      kick();
      wait_pos(9);
      wait_pos(9);
      pause = 1'b1;
      step();
      pause = 1'b0;
      chk("pause_state", 32'(state), 32'd1);
      chk("pause_dac", 32'(dacdat), 32'd0);
      chk("pause_addr", 32'(addr), 32'd2);
      wait_pos(9);
      chk("pause_hold_state", 32'(state), 32'd1);
      chk("pause_hold_addr", 32'(addr), 32'd2);
      kick();
      wait_idle("resume");
      step();
      step();
      model(2, 2'b00, 1, 5);
      expq.push_front(mem[0]);
      expq.push_front(mem[0]);
      check_words("resume");
      chk("resume_addr", 32'(addr), 32'd5);
      chk("resume_done", 32'(done_cnt - d0), 32'd1);

      // Stop and pause together mid-slot: stop wins, no done.
      end_addr = AW'(5);
      d0 = done_cnt;
      kick();
      wait_pos(5);
      stop = 1'b1;
      pause = 1'b1;
      step();
      stop = 1'b0;
      pause = 1'b0;
      chk("stop_state", 32'(state), 32'd0);
      chk("stop_dac", 32'(dacdat), 32'd0);
      repeat (100) step();
      chk("stop_state2", 32'(state), 32'd0);
      chk("stop_nodone", 32'(done_cnt - d0), 32'd0);

      // Asynchronous reset between clock edges.
      kick();
      wait_pos(10);
      chk("prerst_state", 32'(state), 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("arst_state", 32'(state), 32'd0);
      chk("arst_addr", 32'(addr), 32'd0);
      chk("arst_dac", 32'(dacdat), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      step();
      rst = 1'b0;

      // Overflow past the top of a 4-bit address space must terminate.
      stop = 1'b1;
      step();
      stop = 1'b0;
      step();
      ds = done_cnt_s;
      play_run("wrap", 2'b01, 3'd7, 20);
      chk("wrap_s_done", 32'(done_cnt_s - ds), 32'd1);
      chk("wrap_s_addr", 32'(addr_s), 32'd8);
      chk("wrap_s_state", 32'(state_s), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
